// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, debug-loaded instruction memory and IF/ID register.
// Define IF_CYCLE_COUNT_EN to add o_IF_cycles, a count of enabled edges spent in RUN.
module if_stage #(
    parameter int                 NB_PC        = 32,
    parameter int                 NB_INST      = 32,
    parameter int                 NB_IMEM_ADDR = 10,
    parameter logic [NB_INST-1:0] HALT_INST    = {NB_INST{1'b1}}
) (
    input  logic                    i_IF_clock,
    input  logic                    i_IF_reset,
    input  logic                    i_IF_enable,
    input  logic                    i_IF_start,
    input  logic                    i_IF_wr_en,
    input  logic [NB_IMEM_ADDR-1:0] i_IF_wr_addr,
    input  logic [NB_INST-1:0]      i_IF_wr_data,
    input  logic                    i_IF_stall,
    input  logic                    i_IF_flush,
    input  logic                    i_IF_jump,
    input  logic [NB_PC-1:0]        i_IF_jump_address,
    input  logic                    i_IF_branch,
    input  logic [NB_PC-1:0]        i_IF_branch_address,
    output logic [NB_INST-1:0]      o_IF_inst,
    output logic [NB_PC-1:0]        o_IF_pc,
    output logic                    o_IF_valid,
    output logic                    o_IF_halt,
    output logic [1:0]              o_IF_state
`ifdef IF_CYCLE_COUNT_EN
    ,
    output logic [31:0]             o_IF_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    localparam int DEPTH = 1 << NB_IMEM_ADDR;

    state_t             state, state_next;
    logic [NB_PC-1:0]   pc, pc_plus1, next_pc;
    logic [NB_INST-1:0] mem [DEPTH];
    logic [NB_INST-1:0] fetched;
    logic               fetch_en, halt_hit;

    always_comb begin
        pc_plus1 = pc + NB_PC'(1);
        if (i_IF_jump)
            next_pc = i_IF_jump_address;
        else if (i_IF_branch)
            next_pc = i_IF_branch_address;
        else
            next_pc = pc_plus1;
        // The index drops the upper PC bits, so fetch wraps modulo the memory depth.
        fetched  = mem[pc[NB_IMEM_ADDR-1:0]];
        fetch_en = (state == ST_RUN) && !i_IF_flush && !i_IF_stall;
        halt_hit = fetch_en && (fetched == HALT_INST);
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        if (i_IF_enable) begin
            case (state)
                ST_LOAD:   if (i_IF_start) state_next = ST_RUN;
                ST_RUN:    if (halt_hit)   state_next = ST_HALTED;
                ST_HALTED: state_next = ST_HALTED;
                default:   state_next = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge i_IF_clock or negedge i_IF_reset) begin
        if (!i_IF_reset)
            state <= ST_LOAD;
        else
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= state_next;
    end

    always_ff @(posedge i_IF_clock or negedge i_IF_reset) begin
        if (!i_IF_reset) begin
            pc         <= '0;
            o_IF_inst  <= '0;
            o_IF_pc    <= '0;
            o_IF_valid <= 1'b0;
            o_IF_halt  <= 1'b0;
        end else if (i_IF_enable) begin
            case (state)
                ST_RUN: begin
                    if (i_IF_flush) begin
                        o_IF_inst  <= '0;
                        o_IF_pc    <= '0;
                        o_IF_valid <= 1'b0;
                        pc         <= next_pc;
                    end else if (!i_IF_stall) begin
                        o_IF_inst  <= fetched;
                        o_IF_pc    <= pc_plus1;
                        o_IF_valid <= 1'b1;
                        if (halt_hit)
                            o_IF_halt <= 1'b1;
                        else
                            pc <= next_pc;
                    end
                end
                default: begin
                    // LOAD and HALTED both present a NOP bubble; PC stays where it is.
                    o_IF_inst  <= '0;
                    o_IF_pc    <= '0;
                    o_IF_valid <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: memory has no reset so it maps to RAM and the program survives a reset.
    always_ff @(posedge i_IF_clock) begin
        if (i_IF_enable && (state == ST_LOAD) && i_IF_wr_en)
            mem[i_IF_wr_addr] <= i_IF_wr_data;
    end

    assign o_IF_state = state;

`ifdef IF_CYCLE_COUNT_EN
    always_ff @(posedge i_IF_clock or negedge i_IF_reset) begin
        if (!i_IF_reset)
            o_IF_cycles <= '0;
        else if (i_IF_enable && (state == ST_RUN))
            o_IF_cycles <= o_IF_cycles + 32'd1;
    end
`else
    // Cycle counter not built.
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage. It holds the PC and a synchronous instruction memory that the debug unit loads. It also contains the IF/ID pipeline register. The block feeds the decode stage with the instruction word and PC+1, and accepts jump/branch redirects from downstream, stall/flush from the hazard unit, and a start command from the debug unit.

Parameters:
NB_PC, 32, PC and address width
NB_INST, 32, instruction width
NB_IMEM_ADDR, 10, instruction memory word-address width (depth 2^NB_IMEM_ADDR)
HALT_INST, 32'hFFFF_FFFF, encoding that stops fetch

Ports:
i_IF_clock  in  1  clock, rising edge
i_IF_reset  in  1  asynchronous, active-low reset
i_IF_enable  in  1  global step/run enable from debug unit; 0 = freeze all state
i_IF_start  in  1  LOAD->RUN command
i_IF_wr_en  in  1  imem write strobe (LOAD state only)
i_IF_wr_addr  in  NB_IMEM_ADDR  imem write word address
i_IF_wr_data  in  NB_INST  imem write data
i_IF_stall  in  1  hazard unit: hold PC and IF/ID
i_IF_flush  in  1  hazard unit: squash IF/ID contents
i_IF_jump  in  1  jump taken (from decode)
i_IF_jump_address  in  NB_PC  jump target
i_IF_branch  in  1  branch taken
i_IF_branch_address  in  NB_PC  branch target
o_IF_inst  out  NB_INST  IF/ID instruction
o_IF_pc  out  NB_PC  IF/ID PC+1
o_IF_valid  out  1  IF/ID holds a real instruction
o_IF_halt  out  1  halt fetched; sticky
o_IF_state  out  2  00 LOAD, 01 RUN, 10 HALTED

Behaviour:
- Reset (i_IF_reset=0, async): PC=0, o_IF_inst=0, o_IF_pc=0, o_IF_valid=0, o_IF_halt=0, state=LOAD. Imem contents are not reset.
- PC is word-addressed and increments by 1. Imem index = PC[NB_IMEM_ADDR-1:0], so addresses wrap modulo depth.
- i_IF_enable=0: no register changes in any state, including imem writes.

State LOAD:
- i_IF_wr_en=1 writes mem[i_IF_wr_addr] on the clock edge.
- PC is held at 0 and IF/ID is held at NOP/invalid.
- i_IF_start=1 moves the state to RUN on the next edge.
- If i_IF_wr_en and i_IF_start are asserted in the same cycle, the write completes and the state moves to RUN.

State RUN:
- Imem writes are ignored.
- Each enabled cycle, in priority order:
  1. i_IF_flush=1: o_IF_inst=0, o_IF_valid=0, o_IF_pc=0. PC <= next_pc. Flush wins over stall.
  2. Else i_IF_stall=1: PC and IF/ID hold.
  3. Else: o_IF_inst <= mem[PC], o_IF_pc <= PC+1, o_IF_valid <= 1, PC <= next_pc.
- next_pc priority: i_IF_jump ? jump_address : i_IF_branch ? branch_address : PC+1.
- A redirect does not squash the instruction fetched in the same cycle; squashing is done only via i_IF_flush.
- Read latency: the word at PC appears on o_IF_inst one edge after PC presents it.
- Halt detection: in case 3, if mem[PC]==HALT_INST then:
  - the HALT word is delivered with valid=1;
  - PC is not updated;
  - o_IF_halt <= 1;
  - state <= HALTED.
- A stalled or flushed cycle never detects halt.

State HALTED:
- PC is frozen.
- The next enabled edge loads IF/ID with NOP, valid=0; it then holds.
- Stall, flush, jump, branch and start are ignored.
- The only exit is reset.

Other rules:
- Reset asserted mid-RUN returns to LOAD immediately. Imem is preserved, so i_IF_start re-executes the program from PC 0.
- PC+1 and targets are NB_PC bits wide, and the sum wraps at 2^NB_PC.

Optional Feature:
IF_CYCLE_COUNT_EN
- Defined: adds output o_IF_cycles (32 bits), reset to 0. It increments on every enabled edge while state==RUN, including stall and flush cycles. It freezes in HALTED and clears only on reset. The debug unit reads it.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Load/run: write mem[0..3]=0x11,0x22,0x33,HALT, then start. Expected: o_IF_inst 0x11/0x22/0x33/HALT with o_IF_pc 1/2/3/4, valid=1 on 4 consecutive cycles. Then o_IF_halt=1 and state=10, and the next IF/ID is 0 with valid=0.
- Jump: at PC=2, assert i_IF_jump with address 8, with mem[8]=0xAB. Expected: mem[2] is delivered, then 0xAB with o_IF_pc=9. With jump and branch(5) asserted together, the target is 8.
- Stall/flush: assert stall for 3 cycles at PC=1. Expected: o_IF_inst and PC hold for 3 cycles. Then assert stall and flush together. Expected: inst=0, valid=0, PC advances.
- LOAD gating: write in RUN to addr 0 with 0xDEAD. Expected: after reset+start, mem[0] still has its original value. Start+write in the same cycle: the write lands and the state becomes RUN.
- Reset mid-run: pull i_IF_reset low asynchronously between edges at PC=5. Expected: outputs are 0 immediately and state=LOAD. Start again: o_IF_inst=mem[0] with o_IF_pc=1.
- Enable/wrap: with i_IF_enable=0, nothing changes. With NB_IMEM_ADDR=2 and PC=3 and no HALT: the next fetch index is 0, and o_IF_pc=4 then 5. With IF_CYCLE_COUNT_EN, o_IF_cycles counts only enabled RUN edges.
